// File: rtl/se2pa_frame.sv
// se2pa_frame: packs serial complex samples into 4-lane words, framed as
// FRAME-sample FFT frames with first/last word flags and a sticky abort flag.
// Lane 0 of each word is the earliest sample.
// Optional build macro SE2PA_BITREV_EN: buffers a whole frame at bit-reversed
// sample indices, then bursts the FRAME/4 words out while DRDY is held low.
module se2pa_frame #(
  parameter int nb    = 16,
  parameter int FRAME = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            DVAL,
  input  logic [nb-1:0]   DR,
  input  logic [nb-1:0]   DI,
  output logic            DRDY,
  output logic [4*nb-1:0] OR,
  output logic [4*nb-1:0] OI,
  output logic            OVAL,
  output logic            OFIRST,
  output logic            RDY,
  output logic            ERR
);
  localparam int AW = $clog2(FRAME);
  localparam int CW = AW + 1;
  localparam int NW = FRAME / 4;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} st_t;

  st_t           st;
  logic [CW-1:0] cnt;
  logic          acc, last, abort;

  assign acc   = DVAL & DRDY;
  assign last  = (cnt == CW'(FRAME - 1));
  // START on the closing sample of a frame is a normal completion, not an abort
  assign abort = acc & START & (st == FILL) & ~last;

`ifdef SE2PA_BITREV_EN
  localparam int WW = $clog2(NW);

  logic [nb-1:0]   br_r [FRAME];
  logic [nb-1:0]   br_i [FRAME];
  logic [WW:0]     wcnt;
  logic [WW-1:0]   rd_sel;
  logic [AW-1:0]   wr_idx;
  logic            wr_en;
  logic [4*nb-1:0] rd_r, rd_i;

  function automatic logic [AW-1:0] rev(input logic [AW-1:0] a);
    for (int b = 0; b < AW; b++) rev[b] = a[AW-1-b];
  endfunction

  assign wr_en  = acc & ((st == FILL) | START);
  assign wr_idx = ((st == FILL) && !abort) ? rev(cnt[AW-1:0]) : '0;
  // word 0 is read on the closing accept; for FRAME>=8 the closing sample
  // lands in the last word, so word 0 never collides with that write
  assign rd_sel = (st == DRAIN) ? wcnt[WW-1:0] : '0;

  // frame buffer written at the bit-reversed sample index
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      br_r[wr_idx] <= DR;
      br_i[wr_idx] <= DI;
    end
  end

  // gather the four lanes of the word being emitted, natural index order
  always_comb begin
    rd_r = '0;
    rd_i = '0;
    for (int k = 0; k < 4; k++) begin
      rd_r[k*nb +: nb] = br_r[{rd_sel, 2'(k)}];
      rd_i[k*nb +: nb] = br_i[{rd_sel, 2'(k)}];
    end
  end

  // framing FSM: fill the buffer, then burst the words with DRDY held low
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st     <= IDLE;
      cnt    <= '0;
      wcnt   <= '0;
      DRDY   <= 1'b1;
      OR     <= '0;
      OI     <= '0;
      OVAL   <= 1'b0;
      OFIRST <= 1'b0;
      RDY    <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      OVAL   <= 1'b0;
      OFIRST <= 1'b0;
      RDY    <= 1'b0;
      case (st)
        IDLE: begin
          if (acc && START) begin
            cnt <= CW'(1);
            st  <= FILL;
          end
        end
        FILL: begin
          if (abort) begin
            ERR <= 1'b1;
            cnt <= CW'(1);
          end else if (acc) begin
            cnt <= cnt + CW'(1);
            if (last) begin
              OR     <= rd_r;
              OI     <= rd_i;
              OVAL   <= 1'b1;
              OFIRST <= 1'b1;
              RDY    <= (NW == 1);
              wcnt   <= (WW+1)'(1);
              DRDY   <= 1'b0;
              st     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (wcnt != (WW+1)'(NW)) begin
            OR   <= rd_r;
            OI   <= rd_i;
            OVAL <= 1'b1;
            RDY  <= (wcnt == (WW+1)'(NW - 1));
            wcnt <= wcnt + (WW+1)'(1);
          end else begin
            DRDY <= 1'b1;
            st   <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

`else
  logic [2:0][nb-1:0] lr, li;

  assign DRDY = 1'b1;

  // framing FSM: lanes 0..2 are held, lane 3 goes straight into the output word
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st     <= IDLE;
      cnt    <= '0;
      lr     <= '0;
      li     <= '0;
      OR     <= '0;
      OI     <= '0;
      OVAL   <= 1'b0;
      OFIRST <= 1'b0;
      RDY    <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      OVAL   <= 1'b0;
      OFIRST <= 1'b0;
      RDY    <= 1'b0;
      case (st)
        IDLE: begin
          if (acc && START) begin
            lr[0] <= DR;
            li[0] <= DI;
            cnt   <= CW'(1);
            st    <= FILL;
          end
        end
        FILL: begin
          if (abort) begin
            ERR   <= 1'b1;
            lr[0] <= DR;
            li[0] <= DI;
            cnt   <= CW'(1);
          end else if (acc) begin
            cnt <= cnt + CW'(1);
            if (cnt[1:0] == 2'd3) begin
              OR     <= {DR, lr[2], lr[1], lr[0]};
              OI     <= {DI, li[2], li[1], li[0]};
              OVAL   <= 1'b1;
              OFIRST <= (cnt == CW'(3));
              RDY    <= last;
            end else begin
              lr[cnt[1:0]] <= DR;
              li[cnt[1:0]] <= DI;
            end
            if (last) st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_se2pa_frame.sv
// Bench for se2pa_frame: directed scenarios plus a random stream, checked
// cycle by cycle against a frame-level reference model.
module tb_se2pa_frame;
  localparam int nb    = 16;
  localparam int FRAME = 32;
  localparam int NW    = FRAME / 4;
  localparam int AW    = $clog2(FRAME);
`ifdef SE2PA_BITREV_EN
  localparam bit BR = 1'b1;
  localparam logic [4*nb-1:0] W7_SEQ = {16'd31, 16'd15, 16'd23, 16'd7};
`else
  localparam bit BR = 1'b0;
  localparam logic [4*nb-1:0] W7_SEQ = {16'd31, 16'd30, 16'd29, 16'd28};
`endif

  logic            CLK = 1'b0, RST = 1'b0, START = 1'b0, DVAL = 1'b0;
  logic [nb-1:0]   DR = '0, DI = '0;
  logic            DRDY, OVAL, OFIRST, RDY, ERR;
  logic [4*nb-1:0] OR, OI;

  se2pa_frame #(.nb(nb), .FRAME(FRAME)) dut (
    .CLK(CLK), .RST(RST), .START(START), .DVAL(DVAL), .DR(DR), .DI(DI),
    .DRDY(DRDY), .OR(OR), .OI(OI), .OVAL(OVAL), .OFIRST(OFIRST), .RDY(RDY),
    .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [nb-1:0] r, i; } smp_t;
  typedef struct { logic [4*nb-1:0] r, i; logic f, l; } wrd_t;

  smp_t            frm[$];
  wrd_t            exq[$];
  bit              in_frame, err_m, drdy_now;
  int              lowcnt;
  logic [4*nb-1:0] last_r, last_i;
  int              vectors, miscompares;

  task automatic chk(input string tag, input logic [4*nb-1:0] obs, input logic [4*nb-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rev(input int j);
    int r = 0;
    for (int b = 0; b < AW; b++) if (j & (1 << b)) r |= 1 << (AW - 1 - b);
    return r;
  endfunction

  // compare this cycle's outputs with what the model predicts
  task automatic check_outputs();
    wrd_t e;
    drdy_now = (lowcnt == 0);
    chk("DRDY", DRDY, drdy_now);
    if (lowcnt > 0) lowcnt--;
    chk("ERR", ERR, err_m);
    if (exq.size() != 0) begin
      e = exq.pop_front();
      chk("OVAL", OVAL, 1);
      chk("OR", OR, e.r);
      chk("OI", OI, e.i);
      chk("OFIRST", OFIRST, e.f);
      chk("RDY", RDY, e.l);
      last_r = e.r;
      last_i = e.i;
    end else begin
      chk("OVAL_idle", OVAL, 0);
      chk("OFIRST_idle", OFIRST, 0);
      chk("RDY_idle", RDY, 0);
      chk("OR_hold", OR, last_r);
      chk("OI_hold", OI, last_i);
    end
  endtask

  // frame-level model: collects samples, produces words when they complete
  task automatic model(input logic s, input logic v, input logic [nb-1:0] r, input logic [nb-1:0] i);
    smp_t x;
    wrd_t w;
    smp_t a[FRAME];
    int   n;
    if (!(v && drdy_now)) return;
    x.r = r;
    x.i = i;
    if (!in_frame) begin
      if (s) begin
        frm.delete();
        frm.push_back(x);
        in_frame = 1;
      end
      return;
    end
    if (s && frm.size() != FRAME - 1) begin
      err_m = 1;
      frm.delete();
      frm.push_back(x);
      return;
    end
    frm.push_back(x);
    n = frm.size();
    if (!BR && (n % 4) == 0) begin
      for (int k = 0; k < 4; k++) begin
        w.r[k*nb +: nb] = frm[n-4+k].r;
        w.i[k*nb +: nb] = frm[n-4+k].i;
      end
      w.f = (n == 4);
      w.l = (n == FRAME);
      exq.push_back(w);
    end
    if (n == FRAME) begin
      in_frame = 0;
      if (BR) begin
        for (int j = 0; j < FRAME; j++) a[rev(j)] = frm[j];
        for (int wi = 0; wi < NW; wi++) begin
          for (int k = 0; k < 4; k++) begin
            w.r[k*nb +: nb] = a[4*wi+k].r;
            w.i[k*nb +: nb] = a[4*wi+k].i;
          end
          w.f = (wi == 0);
          w.l = (wi == NW - 1);
          exq.push_back(w);
        end
        lowcnt = NW;
      end
    end
  endtask

  task automatic step(input logic s, input logic v, input logic [nb-1:0] r, input logic [nb-1:0] i);
    @(negedge CLK);
    check_outputs();
    START = s;
    DVAL  = v;
    DR    = r;
    DI    = i;
    model(s, v, r, i);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0);
  endtask

  task automatic send(input logic s, input logic [nb-1:0] r, input logic [nb-1:0] i, input int gap);
    for (int k = 0; k < gap; k++) step(1'b0, 1'b0, r ^ 16'h5a5a, i);
    step(s, 1'b1, r, i);
  endtask

  // asynchronous reset between edges; outputs must clear at once
  task automatic do_reset();
    #2;
    START = 1'b0;
    DVAL  = 1'b0;
    RST   = 1'b0;
    #1;
    chk("rst_OR", OR, 0);
    chk("rst_OI", OI, 0);
    chk("rst_OVAL", OVAL, 0);
    chk("rst_OFIRST", OFIRST, 0);
    chk("rst_RDY", RDY, 0);
    chk("rst_ERR", ERR, 0);
    chk("rst_DRDY", DRDY, 1);
    frm.delete();
    exq.delete();
    in_frame = 0;
    err_m    = 0;
    lowcnt   = 0;
    last_r   = '0;
    last_i   = '0;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    do_reset();
    idle(2);

    // contiguous frame DR=n, DI=100+n
    for (int n = 0; n < FRAME; n++) send(n == 0, 16'(n), 16'(100 + n), 0);
    idle(11);
    chk("seq_last_word", OR, W7_SEQ);
    chk("seq_err", ERR, 0);

    // same frame with DVAL low every other cycle
    for (int n = 0; n < FRAME; n++) send(n == 0, 16'(n), 16'(100 + n), 1);
    idle(11);
    chk("alt_last_word", OR, W7_SEQ);

    // samples without START in IDLE are dropped, then a random frame
    for (int n = 0; n < 5; n++) send(1'b0, 16'($urandom), 16'($urandom), 0);
    for (int n = 0; n < FRAME; n++) send(n == 0, 16'($urandom), 16'($urandom), 0);
    idle(11);

    // abort with START at sample 13, new frame starts with that sample
    for (int n = 0; n < 13; n++) send(n == 0, 16'($urandom), 16'($urandom), 0);
    for (int n = 0; n < FRAME; n++) send(n == 0, 16'($urandom), 16'($urandom), 0);
    idle(11);
    chk("abort_err_sticky", ERR, 1);

    // reset mid-frame at sample 20, then a fresh frame
    for (int n = 0; n < 20; n++) send(n == 0, 16'(n), 16'(100 + n), 0);
    @(posedge CLK);
    do_reset();
    for (int n = 0; n < FRAME; n++) send(n == 0, 16'(n), 16'(100 + n), 0);
    idle(11);
    chk("post_rst_last_word", OR, W7_SEQ);

    // START on the closing sample is not an abort; following samples dropped
    for (int n = 0; n < FRAME; n++) send(n == 0 || n == FRAME - 1, 16'($urandom), 16'($urandom), 0);
    for (int n = 0; n < 6; n++) send(1'b0, 16'($urandom), 16'($urandom), 0);
    idle(11);
    chk("late_start_err", ERR, 0);

    // random stream: random stalls, occasional START anywhere
    for (int n = 0; n < 700; n++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom));
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
